// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package mcu_mem_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_I,
    WAIT_D
  } state_t;

  typedef logic grant_t;
  localparam grant_t GNT_I = 1'b0;
  localparam grant_t GNT_D = 1'b1;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Pipeline-side (fetch/data) and memory-side handshake bundle for the arbiter.
interface unified_mem_arbiter_if
  import mcu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ready;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
    output if_rdata, if_ready, dm_rdata, dm_ready, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_ready, dm_rdata, dm_ready, mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/unified_mem_arbiter_mem_grant_select.sv
// Data-first grant selection with a starvation counter protecting instruction fetch.
module mem_grant_select
  import mcu_mem_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   if_req,
  input  logic   dm_req,
  input  logic   grant_event,
  output grant_t grant_d
);

  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] starveCnt;
  logic          starved;

  assign starved = (starveCnt == CW'(STARVE_LIMIT));

  always_comb begin
    grant_d = GNT_I;
    if (dm_req && !(if_req && starved)) begin
      grant_d = GNT_D;
    end
  end

  // Counts only data grants taken while fetch is waiting; any idle fetch cycle forgives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starveCnt <= '0;
    end else if (!if_req) begin
      starveCnt <= '0;
    end else if (grant_event) begin
      if (grant_d == GNT_I) begin
        starveCnt <= '0;
      end else if (!starved) begin
        starveCnt <= starveCnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-ported memory arbiter between fetch and data stages.
// Optional mem_ack timeout enabled by defining UNIFIED_MEM_TIMEOUT_EN.
module unified_mem_arbiter
  import mcu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned MAX_WAIT     = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  unified_mem_arbiter_if.slave   bus,
  output logic                   err_timeout
);

  if (STARVE_LIMIT < 1 || MAX_WAIT < 1) begin : g_badParam
    $error("unified_mem_arbiter: STARVE_LIMIT and MAX_WAIT must be at least 1");
  end

  state_t            state, stateNext;
  grant_t            grantD;
  logic              grantEvent;
  logic              timeoutHit;

  logic              memReqQ, memReqN;
  logic              memWeQ, memWeN;
  logic [ADDR_W-1:0] memAddrQ, memAddrN;
  logic [DATA_W-1:0] memWdataQ, memWdataN;
  logic              ifReadyQ, ifReadyN;
  logic              dmReadyQ, dmReadyN;
  logic [DATA_W-1:0] ifRdataQ, ifRdataN;
  logic [DATA_W-1:0] dmRdataQ, dmRdataN;

  // No grant during any ready pulse: the finishing requester is still dropping req.
  assign grantEvent = (state == IDLE) && !ifReadyQ && !dmReadyQ && (bus.if_req || bus.dm_req);

  mem_grant_select #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_grantSelect (
    .clk         (clk),
    .reset       (reset),
    .if_req      (bus.if_req),
    .dm_req      (bus.dm_req),
    .grant_event (grantEvent),
    .grant_d     (grantD)
  );

`ifdef UNIFIED_MEM_TIMEOUT_EN
  localparam int unsigned WW = $clog2(MAX_WAIT + 1);

  logic [WW-1:0] waitCnt;
  logic          errQ;

  assign timeoutHit = (state != IDLE) && (waitCnt == WW'(MAX_WAIT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      waitCnt <= '0;
      errQ    <= 1'b0;
    end else if (grantEvent) begin
      waitCnt <= '0;
    end else if (state != IDLE) begin
      if (timeoutHit) begin
        if (!bus.mem_ack) begin
          errQ <= 1'b1;
        end
      end else begin
        waitCnt <= waitCnt + 1'b1;
      end
    end
  end

  assign err_timeout = errQ;
`else
  assign timeoutHit  = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    stateNext = state;
    memReqN   = memReqQ;
    memWeN    = memWeQ;
    memAddrN  = memAddrQ;
    memWdataN = memWdataQ;
    ifReadyN  = 1'b0;
    dmReadyN  = 1'b0;
    ifRdataN  = ifRdataQ;
    dmRdataN  = dmRdataQ;
    unique case (state)
      IDLE: begin
        if (grantEvent) begin
          memReqN = 1'b1;
          if (grantD == GNT_D) begin
            stateNext = WAIT_D;
            memWeN    = bus.dm_we;
            memAddrN  = bus.dm_addr;
            memWdataN = bus.dm_wdata;
          end else begin
            stateNext = WAIT_I;
            memWeN    = 1'b0;
            memAddrN  = bus.if_addr;
            memWdataN = '0;
          end
        end
      end
      WAIT_I: begin
        if (bus.mem_ack || timeoutHit) begin
          stateNext = IDLE;
          memReqN   = 1'b0;
          ifReadyN  = 1'b1;
          ifRdataN  = bus.mem_ack ? bus.mem_rdata : '0;
        end
      end
      WAIT_D: begin
        if (bus.mem_ack || timeoutHit) begin
          stateNext = IDLE;
          memReqN   = 1'b0;
          dmReadyN  = 1'b1;
          if (!bus.mem_ack) begin
            dmRdataN = '0;
          end else if (!memWeQ) begin
            dmRdataN = bus.mem_rdata;
          end
        end
      end
      default: begin
        stateNext = IDLE;
        memReqN   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      memReqQ   <= 1'b0;
      memWeQ    <= 1'b0;
      memAddrQ  <= '0;
      memWdataQ <= '0;
      ifReadyQ  <= 1'b0;
      dmReadyQ  <= 1'b0;
      ifRdataQ  <= '0;
      dmRdataQ  <= '0;
    end else begin
      state     <= stateNext;
      memReqQ   <= memReqN;
      memWeQ    <= memWeN;
      memAddrQ  <= memAddrN;
      memWdataQ <= memWdataN;
      ifReadyQ  <= ifReadyN;
      dmReadyQ  <= dmReadyN;
      ifRdataQ  <= ifRdataN;
      dmRdataQ  <= dmRdataN;
    end
  end

  assign bus.mem_req   = memReqQ;
  assign bus.mem_we    = memWeQ;
  assign bus.mem_addr  = memAddrQ;
  assign bus.mem_wdata = memWdataQ;
  assign bus.if_ready  = ifReadyQ;
  assign bus.dm_ready  = dmReadyQ;
  assign bus.if_rdata  = ifRdataQ;
  assign bus.dm_rdata  = dmRdataQ;

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
Shares one single-ported, variable-latency unified memory between two requesters of the five-stage pipeline: the Fetch stage (instruction reads) and the Memory stage (data loads and stores).
Grants one transaction at a time, drives the memory-side request/acknowledge handshake and returns read data with a one-cycle ready pulse.
Data accesses have priority, with a starvation limit that protects instruction fetch.
The pipeline derives StallF/StallD from if_req & ~if_ready, and the M/W freeze from dm_req & ~dm_ready.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data word width
STARVE_LIMIT, 4, maximum consecutive data grants while if_req is pending; the next grant then goes to fetch
MAX_WAIT, 15, maximum cycles waited for mem_ack before timeout (used only with the optional feature)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
if_req  in  1  fetch request; held high until if_ready
if_addr  in  ADDR_W  fetch address; stable while if_req is high
if_rdata  out  DATA_W  instruction word; valid while if_ready is high
if_ready  out  1  one-cycle completion pulse for fetch
dm_req  in  1  data request (MemtoRegM | MemWriteM); held high until dm_ready
dm_we  in  1  1 = store, 0 = load; stable while dm_req is high
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_rdata  out  DATA_W  load data; valid while dm_ready is high
dm_ready  out  1  one-cycle completion pulse for data
mem_req  out  1  memory request, held high until mem_ack
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data; valid together with mem_ack
mem_ack  in  1  memory completion, one cycle
err_timeout  out  1  sticky timeout flag (0 when the optional feature is absent)

Behaviour:
- Reset (async, active low): state IDLE; starve_cnt = 0; all outputs 0 (mem_req, mem_we, mem_addr, mem_wdata, if_ready, dm_ready, if_rdata, dm_rdata, err_timeout).
- States: IDLE, WAIT_I, WAIT_D.
- IDLE, grant selection:
  - dm_req and if_req both high: grant data, unless starve_cnt == STARVE_LIMIT, in which case grant fetch.
  - Only one request high: grant that requester.
  - No request: remain in IDLE.
- On a grant, registered on the next edge: mem_req = 1; mem_addr/mem_we/mem_wdata latched from the granted requester. A fetch grant always sets mem_we = 0.
- WAIT_x: mem_req and all mem_* outputs held constant until mem_ack.
- On mem_ack in WAIT_x, next edge:
  - Return to IDLE; mem_req = 0.
  - The granted requester's ready = 1 for exactly one cycle.
  - For a read, its rdata register = mem_rdata. For a store, dm_rdata is unchanged.
- Latency: request seen in IDLE at edge n gives mem_req high after edge n. mem_ack at edge n+k gives ready high after edge n+k. Minimum request-to-ready is 2 cycles.
- The ready pulse cycle is spent in IDLE, so no new grant is issued in that cycle. The requester drops req in that same cycle, and the arbiter ignores req while that requester's ready is high. A new grant can issue on the following edge.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on each data grant while if_req is high.
  - Clears on a fetch grant, and in any cycle where if_req is low.
- A mem_ack received in IDLE is ignored (stale ack after reset).
- A requester dropping req mid-transaction violates the protocol; the transaction completes anyway and the ready pulse is still emitted.
- rdata outputs hold their last value between pulses.

Optional Feature:
UNIFIED_MEM_TIMEOUT_EN.
- Defined:
  - A wait counter clears on each grant and increments each cycle in WAIT_x.
  - If it reaches MAX_WAIT with no mem_ack: return to IDLE; mem_req = 0; pulse the requester's ready with rdata = 0; set err_timeout = 1 (cleared only by reset).
  - A mem_ack arriving later, in IDLE, is ignored.
- Undefined: no counter; the arbiter waits indefinitely for mem_ack; err_timeout is tied to 0.

Decomposition:
- Package mcu_mem_pkg:
  - state enum {IDLE, WAIT_I, WAIT_D};
  - grant encoding constants GNT_I = 0, GNT_D = 1;
  - default ADDR_W/DATA_W.
- One sub-module, mem_grant_select: combinational priority selection plus the registered starve_cnt. Inputs if_req, dm_req, grant_event; output grant_d.

Test Plan:
1. Fetch only: if_req=1, if_addr=0x00000010; mem_ack 3 cycles after mem_req rises with mem_rdata=0x8C220004 -> mem_addr=0x10, mem_we=0; if_ready pulses 1 cycle with if_rdata=0x8C220004; dm_ready stays 0.
2. Store: dm_req=1, dm_we=1, dm_addr=0x40, dm_wdata=0xDEADBEEF; ack after 1 cycle -> mem_we=1, mem_wdata=0xDEADBEEF; dm_ready single pulse; dm_rdata unchanged.
3. Contention: if_req and dm_req held continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,D,D,D,I; fetch is never starved beyond 4 data grants.
4. Reset mid-WAIT_D: assert reset while mem_req=1 -> all outputs 0 immediately (async); a mem_ack one cycle after reset release causes no ready pulse.
5. With UNIFIED_MEM_TIMEOUT_EN and MAX_WAIT=15, dm_req load with no ack -> after 15 WAIT cycles dm_ready pulses, dm_rdata=0, err_timeout=1 and stays 1; a later mem_ack is ignored.
6. Back-to-back loads: dm_req reasserted the cycle after dm_ready -> new mem_req rises on the next edge; no cycle has both if_ready and dm_ready high.
